cog_ram_loader: RTL
===================

// Module: cog_ram_loader
// PURPOSE
// - Sequences and shares the single-port 512x32 cog RAM between the cog execution port and a hub-to-cog loader.
// - On a start pulse, copies LOAD_COUNT longs from hub memory into cog RAM addresses 0..LOAD_COUNT-1, then pulses done.
// - While idle, forwards cog accesses to the RAM unchanged; while loading, stalls the cog and owns the RAM port.
// PARAMETERS
// - BIT_DEPTH   9    cog RAM address width; must match the RAM instance.
// - LOAD_COUNT  496  longs copied per load; 1..(1<<BIT_DEPTH).
// - HUB_AW      14   hub long-address width.
// PORTS
// - clk       in   1          system clock; all logic on posedge.
// - nres      in   1          reset, asynchronous, active-low.
// - start     in   1          1-cycle load request.
// - start_adr in   HUB_AW     hub long address of the first long; sampled with start.
// - abort     in   1          terminate a load early.
// - busy      out  1          load in progress; cog accesses are stalled.
// - done      out  1          1-cycle pulse when the final long is written.
// - hub_req   out  1          hub read request.
// - hub_adr   out  HUB_AW     hub long address; valid while hub_req=1.
// - hub_ack   in   1          hub read complete; hub_dat is valid this cycle.
// - hub_dat   in   32         hub read data.
// - cog_ena   in   1          cog RAM access enable.
// - cog_w     in   1          cog RAM write.
// - cog_a     in   BIT_DEPTH  cog RAM address.
// - cog_d     in   32         cog RAM write data.
// - cog_q     out  32         read data; equals ram_q (RAM register, 1-cycle read latency).
// - ram_ena   out  1          to RAM ena.
// - ram_w     out  1          to RAM w.
// - ram_a     out  BIT_DEPTH  to RAM a.
// - ram_d     out  32         to RAM d.
// - ram_q     in   32         from RAM q.
// BEHAVIOUR
// - Reset (nres=0): state=IDLE, cnt=0, hub_adr=0, hub_req=0, done=0, busy=0. The ram_* outputs pass the cog_* inputs through.
// - States: IDLE, LOAD, DONE. The state and registered outputs change only on posedge clk or async reset.
// - IDLE:
//   - ram_ena/w/a/d = cog_ena/w/a/d (combinational).
//   - start=1 -> next cycle LOAD, cnt=0, hub_adr=start_adr, hub_req=1, busy=1.
// - LOAD:
//   - busy=1 and hub_req=1; the cog inputs are ignored (the cog must hold off while busy).
//   - hub_ack=0: hold; hub_adr, cnt and hub_req are stable.
//   - hub_ack=1: same cycle ram_ena=1, ram_w=1, ram_a=cnt[BIT_DEPTH-1:0], ram_d=hub_dat.
//   - Next cycle after that ack: cnt+1, hub_adr+1 (wraps modulo 2^HUB_AW).
//   - Ack with cnt=LOAD_COUNT-1: write that long, then next cycle DONE, hub_req=0.
//   - Outside an ack cycle: ram_ena=0, ram_w=0.
// - DONE: done=1 and busy=0 for exactly one cycle; the cog port is forwarded; then IDLE.
// - Throughput: 1 long per hub_ack. hub_req stays high back-to-back across acks.
// - Minimum load latency: LOAD_COUNT+2 cycles from start to done.
// - Boundary and simultaneous cases:
//   - start during LOAD or DONE: ignored.
//   - abort in LOAD: next cycle IDLE, hub_req=0, busy=0, no done. An abort-cycle hub_ack still writes its long.
//   - abort and start together in IDLE: start wins.
//   - abort outside LOAD: no effect.
//   - LOAD_COUNT=1: single write, then DONE.
//   - cnt is BIT_DEPTH+1 bits wide, so LOAD_COUNT=(1<<BIT_DEPTH) does not overflow.
//   - nres asserted mid-load: immediate IDLE, hub_req=0; partial RAM contents are left as written.
// STRUCTURE
// - Package cog_ram_pkg: state enum {IDLE, LOAD, DONE}, COG_BIT_DEPTH=9, COG_LOAD_COUNT=496, HUB_AW=14.
// - Single module, no sub-modules. The RAM port mux is combinational from state; the RAM stays a separate instance.
// TESTING
// - Reset then idle cog traffic: cog write 0x1F0<-0xDEADBEEF, then read 0x1F0.
//   -> cog_q=0xDEADBEEF one cycle after the read; busy=0.
// - Full load, start_adr=0x0100, hub_ack every cycle, hub_dat=adr^0xA5A5A5A5:
//   -> RAM[i] = (0x100+i)^0xA5A5A5A5 for i=0..495.
//   -> done pulses once at cycle 498; RAM[496..511] untouched.
// - Random hub_ack gaps (0-5 cycles): hub_adr/cnt stable while ack=0; contents as above; done after the 496th ack.
// - start_adr=0x3FFF: hub_adr wraps to 0x0000 on the second long.
// - abort after 10 acks: busy falls next cycle; hub_req=0; no done; RAM[0..9] written, RAM[10] unchanged.
// - Second start mid-load is ignored; nres pulse mid-load returns IDLE and the cog read path works next cycle.

Source files
------------

// File: rtl/cog_ram_pkg.sv
// Shared types and sizing for the cog RAM loader.
package cog_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int COG_BIT_DEPTH  = 9;
    localparam int COG_LOAD_COUNT = 496;
    localparam int HUB_AW         = 14;

endpackage

// File: rtl/cog_ram_loader.sv
// Shares the single-port cog RAM between the cog and a hub-to-cog block loader.
// Idle: the cog port passes straight through. Loading: the cog is stalled and hub longs are written.
module cog_ram_loader
    import cog_ram_pkg::*;
#(
    parameter int BIT_DEPTH  = COG_BIT_DEPTH,
    parameter int LOAD_COUNT = COG_LOAD_COUNT,
    parameter int HUB_AW     = cog_ram_pkg::HUB_AW
) (
    input  logic                 clk,
    input  logic                 nres,
    input  logic                 start,
    input  logic [HUB_AW-1:0]    start_adr,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 hub_req,
    output logic [HUB_AW-1:0]    hub_adr,
    input  logic                 hub_ack,
    input  logic [31:0]          hub_dat,
    input  logic                 cog_ena,
    input  logic                 cog_w,
    input  logic [BIT_DEPTH-1:0] cog_a,
    input  logic [31:0]          cog_d,
    output logic [31:0]          cog_q,
    output logic                 ram_ena,
    output logic                 ram_w,
    output logic [BIT_DEPTH-1:0] ram_a,
    output logic [31:0]          ram_d,
    input  logic [31:0]          ram_q
);

    // One extra bit so a full-depth load count is representable.
    localparam logic [BIT_DEPTH:0] LAST = (BIT_DEPTH+1)'(LOAD_COUNT - 1);

    state_t             state;
    logic [BIT_DEPTH:0] cnt;

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state   <= IDLE;
            cnt     <= '0;
            hub_adr <= '0;
            hub_req <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        cnt     <= '0;
                        hub_adr <= start_adr;
                        hub_req <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    // An ack arriving with abort is still written by the mux below.
                    if (abort) begin
                        state   <= IDLE;
                        hub_req <= 1'b0;
                        busy    <= 1'b0;
                    end else if (hub_ack) begin
                        cnt     <= cnt + 1'b1;
                        hub_adr <= hub_adr + 1'b1;
                        if (cnt == LAST) begin
                            state   <= DONE;
                            hub_req <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ram_ena = cog_ena;
        ram_w   = cog_w;
        ram_a   = cog_a;
        ram_d   = cog_d;
        if (state == LOAD) begin
            ram_ena = hub_ack;
            ram_w   = hub_ack;
            ram_a   = cnt[BIT_DEPTH-1:0];
            ram_d   = hub_dat;
        end
    end

    assign cog_q = ram_q;

endmodule
